// File: rtl/fft8_sol5_gen2_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : fft8_sol5_gen2_if                                            |
// | Purpose   : Frame-level bus of the 8-point FFT block. It groups the       |
// |             capture request, the parallel input frame, the parallel      |
// |             result frame and the completion flag.                        |
// | Signals   : start          capture request (master -> slave)             |
// |             data_in_real   x[n] real parts, Q1.15 [8] (master -> slave)   |
// |             data_in_imag   x[n] imag parts, Q1.15 [8] (master -> slave)   |
// |             data_out_real  X[k] real parts, natural order [8] (slave ->) |
// |             data_out_imag  X[k] imag parts, natural order [8] (slave ->) |
// |             done           result valid level (slave -> master)          |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface fft8_sol5_gen2_if;
   logic               start;
   logic signed [15:0] data_in_real  [8];
   logic signed [15:0] data_in_imag  [8];
   logic signed [15:0] data_out_real [8];
   logic signed [15:0] data_out_imag [8];
   logic               done;

   modport master (
      output start,
      output data_in_real,
      output data_in_imag,
      input  data_out_real,
      input  data_out_imag,
      input  done
   );

   modport slave (
      input  start,
      input  data_in_real,
      input  data_in_imag,
      output data_out_real,
      output data_out_imag,
      output done
   );
endinterface
`default_nettype wire

// File: rtl/fft8_sol5_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : fft8_sol5_gen2                                               |
// | Purpose   : 8-point radix-2 decimation-in-time FFT on Q1.15 complex      |
// |             samples. A frame is captured in bit-reversed order on start, |
// |             one butterfly stage is computed per clock, and the natural-  |
// |             order bins are presented in parallel with a done level.      |
// |             Every butterfly halves its outputs, so the result is DFT/8.  |
// | Ports     : clk  rising-edge clock                                       |
// |             rst  asynchronous, active-low reset                          |
// |             bus  fft8_sol5_gen2_if.slave (start, data_in_*, data_out_*,  |
// |                  done)                                                   |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module fft8_sol5_gen2 (
   input  logic            clk,
   input  logic            rst,
   fft8_sol5_gen2_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ST1  = 3'd1,
      S_ST2  = 3'd2,
      S_ST3  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Only W1 and W3 go through the multiplier; W0 and W2 are exact.
   localparam logic signed [15:0] c_w1_re =  16'sd23170;
   localparam logic signed [15:0] c_w1_im = -16'sd23170;
   localparam logic signed [15:0] c_w3_re = -16'sd23170;
   localparam logic signed [15:0] c_w3_im = -16'sd23170;

   state_t             state_q, state_d;
   logic signed [15:0] work_re_q [8], work_re_d [8];
   logic signed [15:0] work_im_q [8], work_im_d [8];
   logic signed [15:0] out_re_q  [8], out_re_d  [8];
   logic signed [15:0] out_im_q  [8], out_im_d  [8];
   logic               done_q, done_d;

   logic signed [15:0] load_re [8];
   logic signed [15:0] load_im [8];
   logic signed [15:0] st_re   [3][8];
   logic signed [15:0] st_im   [3][8];

   // Round half-up at bit 15, then clamp into the 16-bit range.
   function automatic logic signed [15:0] round_sat(input logic signed [31:0] acc);
      logic signed [31:0] r;
      r = (acc + 32'sd16384) >>> 15;
      if (r > 32'sd32767)
         return 16'sh7fff;
      else if (r < -32'sd32768)
         return 16'sh8000;
      else
         return r[15:0];
   endfunction

   // Twiddle product B*W^k returned as {re, im}, each 17 bits so that
   // negating -32768 in the W2 path stays exact.
   function automatic logic [33:0] twiddle_mul(input logic signed [15:0] b_re,
                                               input logic signed [15:0] b_im,
                                               input logic [1:0]         k);
      logic signed [31:0] br, bi, cr, ci;
      logic signed [16:0] t_re, t_im;
      br = 32'(b_re);
      bi = 32'(b_im);
      cr = 32'(c_w1_re);
      ci = 32'(c_w1_im);
      t_re = 17'(b_re);
      t_im = 17'(b_im);
      case (k)
         2'd0: begin
            t_re = 17'(b_re);
            t_im = 17'(b_im);
         end
         2'd2: begin
            // (br + j*bi) * (-j) = bi - j*br
            t_re = 17'(b_im);
            t_im = -(17'(b_re));
         end
         default: begin
            if (k == 2'd3) begin
               cr = 32'(c_w3_re);
               ci = 32'(c_w3_im);
            end
            t_re = 17'(round_sat(br * cr - bi * ci));
            t_im = 17'(round_sat(br * ci + bi * cr));
         end
      endcase
      return {t_re, t_im};
   endfunction

   // Scaled butterfly: returns {A'_re, A'_im, B'_re, B'_im}. The 17-bit sum
   // cannot overflow, and dropping bit 0 is the truncating >>>1.
   function automatic logic [63:0] butterfly(input logic signed [15:0] a_re,
                                             input logic signed [15:0] a_im,
                                             input logic signed [15:0] b_re,
                                             input logic signed [15:0] b_im,
                                             input logic [1:0]         k);
      logic [33:0]        t;
      logic signed [16:0] t_re, t_im, s_re, s_im, d_re, d_im;
      t    = twiddle_mul(b_re, b_im, k);
      t_re = t[33:17];
      t_im = t[16:0];
      s_re = 17'(a_re) + t_re;
      s_im = 17'(a_im) + t_im;
      d_re = 17'(a_re) - t_re;
      d_im = 17'(a_im) - t_im;
      return {s_re[16:1], s_im[16:1], d_re[16:1], d_im[16:1]};
   endfunction

   // Capture path: working slot i takes sample bitrev(i).
   for (genvar i = 0; i < 8; i++) begin : g_load
      localparam int REV = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
      assign load_re[i] = bus.data_in_real[REV];
      assign load_im[i] = bus.data_in_imag[REV];
   end

   // One fixed butterfly network per stage; indices and twiddle exponents are
   // elaboration constants, so stages 1 and 2 contain no multipliers.
   for (genvar s = 0; s < 3; s++) begin : g_stage
      localparam int SPAN = 1 << s;
      for (genvar b = 0; b < 4; b++) begin : g_bfly
         localparam int         IA = ((b >> s) << (s + 1)) + (b % SPAN);
         localparam int         IB = IA + SPAN;
         localparam logic [1:0] K  = 2'((b % SPAN) << (2 - s));
         logic [63:0] w_res;
         assign w_res = butterfly(work_re_q[IA], work_im_q[IA],
                                  work_re_q[IB], work_im_q[IB], K);
         assign st_re[s][IA] = w_res[63:48];
         assign st_im[s][IA] = w_res[47:32];
         assign st_re[s][IB] = w_res[31:16];
         assign st_im[s][IB] = w_res[15:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      work_re_d = work_re_q;
      work_im_d = work_im_q;
      out_re_d  = out_re_q;
      out_im_d  = out_im_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               work_re_d = load_re;
               work_im_d = load_im;
               state_d   = S_ST1;
            end
         end
         S_ST1: begin
            work_re_d = st_re[0];
            work_im_d = st_im[0];
            state_d   = S_ST2;
         end
         S_ST2: begin
            work_re_d = st_re[1];
            work_im_d = st_im[1];
            state_d   = S_ST3;
         end
         S_ST3: begin
            out_re_d = st_re[2];
            out_im_d = st_im[2];
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            work_re_q[i] <= '0;
            work_im_q[i] <= '0;
            out_re_q[i]  <= '0;
            out_im_q[i]  <= '0;
         end
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         work_re_q <= work_re_d;
         work_im_q <= work_im_d;
         out_re_q  <= out_re_d;
         out_im_q  <= out_im_d;
      end
   end

   for (genvar i = 0; i < 8; i++) begin : g_out
      assign bus.data_out_real[i] = out_re_q[i];
      assign bus.data_out_imag[i] = out_im_q[i];
   end
   assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fft8_sol5_gen2.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_fft8_sol5_gen2                                            |
// | Purpose   : Self-checking bench for fft8_sol5_gen2: directed frames      |
// |             (impulse, DC, Nyquist, tone) against expected bins, random   |
// |             frames against an integer DIT reference, and control cases.  |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fft8_sol5_gen2;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   int xr [8], xi [8];   // frame being applied
   int er [8], ei [8];   // reference result for that frame
   int hr [8], hi [8];   // previously completed result

   fft8_sol5_gen2_if bus ();

   fft8_sol5_gen2 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic int sat16(int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int bitrev3(int n);
      return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
   endfunction

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   // b * W8^e with the block's fixed-point rules
   task automatic cmul(input int br, input int bi, input int e, output int tr, output int ti);
      int wr, wi;
      case (e)
         0: begin tr = br; ti = bi; end
         2: begin tr = bi; ti = -br; end
         default: begin
            wr = (e == 1) ? 23170 : -23170;
            wi = -23170;
            tr = sat16((br * wr - bi * wi + 16384) >>> 15);
            ti = sat16((br * wi + bi * wr + 16384) >>> 15);
         end
      endcase
   endtask

   // Iterative in-place radix-2 DIT over the bit-reversed frame.
   task automatic model_fft();
      int ar [8], ai [8];
      int tr, ti, p, q;
      for (int n = 0; n < 8; n++) begin
         ar[n] = xr[bitrev3(n)];
         ai[n] = xi[bitrev3(n)];
      end
      for (int h = 1; h < 8; h = h * 2)
         for (int g = 0; g < 8; g = g + 2 * h)
            for (int j = 0; j < h; j++) begin
               p = g + j;
               q = p + h;
               cmul(ar[q], ai[q], j * (4 / h), tr, ti);
               {ar[p], ar[q]} = {(ar[p] + tr) >>> 1, (ar[p] - tr) >>> 1};
               {ai[p], ai[q]} = {(ai[p] + ti) >>> 1, (ai[p] - ti) >>> 1};
            end
      for (int k = 0; k < 8; k++) begin
         er[k] = ar[k];
         ei[k] = ai[k];
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_frame();
      for (int i = 0; i < 8; i++) begin
         bus.data_in_real[i] = 16'(xr[i]);
         bus.data_in_imag[i] = 16'(xi[i]);
      end
   endtask

   task automatic start_frame();
      apply_frame();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!bus.done && n < 20) begin
         tick();
         n++;
      end
   endtask

   function automatic int rand_sample();
      case ($urandom_range(0, 4))
         0:       return -32768;
         1:       return 32767;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   task automatic random_frame();
      for (int i = 0; i < 8; i++) begin
         xr[i] = rand_sample();
         xi[i] = rand_sample();
      end
   endtask

   task automatic save_result();
      for (int k = 0; k < 8; k++) begin
         hr[k] = er[k];
         hi[k] = ei[k];
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      random_frame();
      apply_frame();
      bus.start = 1'b1;
      repeat (3) tick();
      total++;
      if (bus.done !== 1'b0) begin
         bad++; $display("FAIL reset_done: got %b expected 0", bus.done);
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (bus.data_out_real[k] !== 16'h0000 || bus.data_out_imag[k] !== 16'h0000) begin
            bad++;
            $display("FAIL reset_out X[%0d]: got %h+j%h expected 0000+j0000",
                     k, bus.data_out_real[k], bus.data_out_imag[k]);
         end
      end
      bus.start = 1'b0;
      rst = 1'b1;
      repeat (5) tick();
      total++;
      if (bus.done !== 1'b0) begin
         bad++; $display("FAIL idle_done: got %b expected 0", bus.done);
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (bus.data_out_real[k] !== 16'h0000 || bus.data_out_imag[k] !== 16'h0000) begin
            bad++;
            $display("FAIL idle_out X[%0d]: got %h+j%h expected 0000+j0000",
                     k, bus.data_out_real[k], bus.data_out_imag[k]);
         end
      end
   endtask

   task automatic test_impulse();
      int n;
      for (int i = 0; i < 8; i++) begin xr[i] = 0; xi[i] = 0; end
      xr[0] = 16'h4000;
      start_frame();
      wait_done(n);
      total++;
      if (n !== 3) begin
         bad++; $display("FAIL impulse_latency: got %0d edges expected 3 after capture", n);
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (bus.data_out_real[k] !== 16'h0800 || bus.data_out_imag[k] !== 16'h0000) begin
            bad++;
            $display("FAIL impulse X[%0d]: got %h+j%h expected 0800+j0000",
                     k, bus.data_out_real[k], bus.data_out_imag[k]);
         end
      end
      repeat (4) tick();
      total++;
      if (bus.done !== 1'b1 || bus.data_out_real[3] !== 16'h0800) begin
         bad++;
         $display("FAIL impulse_hold: got done=%b X3=%h expected done=1 X3=0800",
                  bus.done, bus.data_out_real[3]);
      end
      for (int k = 0; k < 8; k++) begin er[k] = 16'h0800; ei[k] = 0; end
   endtask

   task automatic test_dc();
      int n, xre, xim;
      for (int i = 0; i < 8; i++) begin xr[i] = 16'h1000; xi[i] = 16'h1000; end
      start_frame();
      wait_done(n);
      for (int k = 0; k < 8; k++) begin
         xre = (k == 0) ? 16'h1000 : 0;
         xim = (k == 0) ? 16'h1000 : 0;
         total++;
         if (iabs(int'(bus.data_out_real[k]) - xre) > 1 || iabs(int'(bus.data_out_imag[k]) - xim) > 1) begin
            bad++;
            $display("FAIL dc X[%0d]: got %0d+j%0d expected %0d+j%0d (+/-1)",
                     k, bus.data_out_real[k], bus.data_out_imag[k], xre, xim);
         end
      end
   endtask

   task automatic test_nyquist();
      int n, xre;
      for (int i = 0; i < 8; i++) begin
         xr[i] = (i % 2 == 0) ? 4096 : -4096;
         xi[i] = 0;
      end
      start_frame();
      wait_done(n);
      for (int k = 0; k < 8; k++) begin
         xre = (k == 4) ? 4096 : 0;
         total++;
         if (iabs(int'(bus.data_out_real[k]) - xre) > 1 || iabs(int'(bus.data_out_imag[k])) > 1) begin
            bad++;
            $display("FAIL nyquist X[%0d]: got %0d+j%0d expected %0d+j0 (+/-1)",
                     k, bus.data_out_real[k], bus.data_out_imag[k], xre);
         end
      end
   endtask

   task automatic test_tone();
      int n, xre;
      int tre [8] = '{8192, 5793, 0, -5793, -8192, -5793, 0, 5793};
      int tim [8] = '{0, 5793, 8192, 5793, 0, -5793, -8192, -5793};
      for (int i = 0; i < 8; i++) begin xr[i] = tre[i]; xi[i] = tim[i]; end
      start_frame();
      wait_done(n);
      for (int k = 0; k < 8; k++) begin
         xre = (k == 1) ? 8192 : 0;
         total++;
         if (iabs(int'(bus.data_out_real[k]) - xre) > 2 || iabs(int'(bus.data_out_imag[k])) > 2) begin
            bad++;
            $display("FAIL tone X[%0d]: got %0d+j%0d expected %0d+j0 (+/-2)",
                     k, bus.data_out_real[k], bus.data_out_imag[k], xre);
         end
      end
   endtask

   task automatic test_random();
      int n;
      for (int f = 0; f < 24; f++) begin
         random_frame();
         model_fft();
         start_frame();
         wait_done(n);
         total++;
         if (n !== 3) begin
            bad++; $display("FAIL random_latency frame %0d: got %0d expected 3", f, n);
         end
         for (int k = 0; k < 8; k++) begin
            total++;
            if (int'(bus.data_out_real[k]) !== er[k] || int'(bus.data_out_imag[k]) !== ei[k]) begin
               bad++;
               $display("FAIL random frame %0d X[%0d]: got %0d+j%0d expected %0d+j%0d",
                        f, k, bus.data_out_real[k], bus.data_out_imag[k], er[k], ei[k]);
            end
         end
      end
   endtask

   task automatic test_start_ignored();
      random_frame();
      model_fft();
      start_frame();          // now in ST1
      tick();                 // now in ST2
      random_frame();         // different frame presented with start high
      apply_frame();
      bus.start = 1'b1;
      tick();                 // ST2 edge: start must be ignored
      bus.start = 1'b0;
      total++;
      if (bus.done !== 1'b0) begin
         bad++; $display("FAIL ignore_early_done: got %b expected 0", bus.done);
      end
      tick();
      total++;
      if (bus.done !== 1'b1) begin
         bad++; $display("FAIL ignore_done_timing: got %b expected 1", bus.done);
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (int'(bus.data_out_real[k]) !== er[k] || int'(bus.data_out_imag[k]) !== ei[k]) begin
            bad++;
            $display("FAIL ignore X[%0d]: got %0d+j%0d expected %0d+j%0d",
                     k, bus.data_out_real[k], bus.data_out_imag[k], er[k], ei[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      for (int f = 0; f < 6; f++) begin
         save_result();
         random_frame();
         model_fft();
         start_frame();       // captured from DONE
         total++;
         if (bus.done !== 1'b0) begin
            bad++; $display("FAIL restart_done_low frame %0d: got %b expected 0", f, bus.done);
         end
         for (int k = 0; k < 8; k++) begin
            total++;
            if (int'(bus.data_out_real[k]) !== hr[k] || int'(bus.data_out_imag[k]) !== hi[k]) begin
               bad++;
               $display("FAIL restart_hold frame %0d X[%0d]: got %0d+j%0d expected %0d+j%0d",
                        f, k, bus.data_out_real[k], bus.data_out_imag[k], hr[k], hi[k]);
            end
         end
         wait_done(n);
         total++;
         if (n !== 3) begin
            bad++; $display("FAIL restart_latency frame %0d: got %0d expected 3", f, n);
         end
         for (int k = 0; k < 8; k++) begin
            total++;
            if (int'(bus.data_out_real[k]) !== er[k] || int'(bus.data_out_imag[k]) !== ei[k]) begin
               bad++;
               $display("FAIL restart frame %0d X[%0d]: got %0d+j%0d expected %0d+j%0d",
                        f, k, bus.data_out_real[k], bus.data_out_imag[k], er[k], ei[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      random_frame();
      model_fft();
      start_frame();
      tick();                 // in ST2
      #2;
      rst = 1'b0;             // asynchronous, between edges
      #1;
      total++;
      if (bus.done !== 1'b0) begin
         bad++; $display("FAIL midreset_done: got %b expected 0", bus.done);
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (bus.data_out_real[k] !== 16'h0000 || bus.data_out_imag[k] !== 16'h0000) begin
            bad++;
            $display("FAIL midreset_out X[%0d]: got %h+j%h expected 0000+j0000",
                     k, bus.data_out_real[k], bus.data_out_imag[k]);
         end
      end
      tick();
      rst = 1'b1;
      repeat (5) tick();
      total++;
      if (bus.done !== 1'b0 || bus.data_out_real[0] !== 16'h0000) begin
         bad++;
         $display("FAIL midreset_idle: got done=%b X0=%h expected done=0 X0=0000",
                  bus.done, bus.data_out_real[0]);
      end
      random_frame();
      model_fft();
      start_frame();
      wait_done(n);
      total++;
      if (n !== 3) begin
         bad++; $display("FAIL recover_latency: got %0d expected 3", n);
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (int'(bus.data_out_real[k]) !== er[k] || int'(bus.data_out_imag[k]) !== ei[k]) begin
            bad++;
            $display("FAIL recover X[%0d]: got %0d+j%0d expected %0d+j%0d",
                     k, bus.data_out_real[k], bus.data_out_imag[k], er[k], ei[k]);
         end
      end
   endtask

   initial begin
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.data_in_real[i] = '0;
         bus.data_in_imag[i] = '0;
      end
      test_reset();
      test_impulse();
      test_dc();
      test_nyquist();
      test_tone();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
